// File: rtl/vector_ram_pkg.sv
// Shared types and helpers for the banked vector scratchpad: FSM states,
// lane-address decoding and the per-bank lowest-index arbiter.
package vector_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int MAX_LANES = 64;

    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bank_bits);
        return addr & ((32'd1 << bank_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] row_of(input logic [31:0] addr, input int bank_bits);
        return addr >> bank_bits;
    endfunction

    // Isolates the lowest set bit: the lowest-index pending lane wins the bank.
    function automatic logic [MAX_LANES-1:0] grant_lowest(input logic [MAX_LANES-1:0] req);
        return req & (~req + 1'b1);
    endfunction

endpackage

// File: rtl/vector_bank_ram_if.sv
// Request/response bundle between a vector compute unit (master) and the
// banked scratchpad (slave).
interface vector_bank_ram_if #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4
);
    logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] addr;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wdata;
    logic [PARALLELISM-1:0]                 lane_en;
    logic                                   write;
    logic                                   valid;
    logic                                   ready;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rdata;
    logic                                   rvalid;
    logic                                   rready;

    modport master (
        output addr, wdata, lane_en, write, valid, rready,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  addr, wdata, lane_en, write, valid, rready,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/vector_ram_bank.sv
// Single-port synchronous RAM bank: 1-cycle read latency, write-first,
// contents are never reset.
module vector_ram_bank #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    localparam int ROW_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ROW_W-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q       <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/vector_bank_ram.sv
// Banked vector scratchpad: serialises bank conflicts one vector at a time.
// Optional conflict-cycle counter enabled by VECTOR_BANK_RAM_PERF_EN.
module vector_bank_ram
    import vector_ram_pkg::*;
#(
    parameter int NUMBER_OF_RAMS = 4,
    parameter int VECTOR_LENGTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PARALLELISM    = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef VECTOR_BANK_RAM_PERF_EN
    output logic [31:0]        conflict_cycles,
`endif
    vector_bank_ram_if.slave   bus
);
    localparam int ADDR_WIDTH = $clog2(VECTOR_LENGTH);
    localparam int BANK_BITS  = $clog2(NUMBER_OF_RAMS);
    localparam int ROWS       = VECTOR_LENGTH / NUMBER_OF_RAMS;
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LANE_W     = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1;

    state_e                                 state_q, state_d;
    logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                                   write_q;
    logic [PARALLELISM-1:0]                 pending_q, pending_d, granted;
    logic [NUMBER_OF_RAMS-1:0][PARALLELISM-1:0] gnt;
    logic [NUMBER_OF_RAMS-1:0][LANE_W-1:0]  gnt_lane, rd_lane_q;
    logic [NUMBER_OF_RAMS-1:0][ROW_W-1:0]   bank_row;
    logic [NUMBER_OF_RAMS-1:0][DATA_WIDTH-1:0] bank_wdata, bank_dout;
    logic [NUMBER_OF_RAMS-1:0]              bank_en, rd_vld_q;
    logic [MAX_LANES-1:0]                   req, req_gnt;
    logic [31:0]                            sel_addr, row_tmp;
    logic                                   accept, issue;
    logic                                   unused_bits;

    // Per-bank arbitration; issue is suppressed while rst is high so the
    // abandoned request writes nothing further.
    always_comb begin
        issue     = (state_q == ISSUE) && !rst;
        granted   = '0;
        req       = '0;
        req_gnt   = '0;
        sel_addr  = '0;
        row_tmp   = '0;
        gnt       = '0;
        gnt_lane  = '0;
        bank_row  = '0;
        bank_wdata = '0;
        bank_en   = '0;
        for (int b = 0; b < NUMBER_OF_RAMS; b++) begin
            req      = '0;
            sel_addr = '0;
            for (int l = 0; l < PARALLELISM; l++) begin
                if (pending_q[l] && (bank_of(32'(addr_q[l]), BANK_BITS) == 32'(b)))
                    req[l] = 1'b1;
            end
            req_gnt = grant_lowest(req);
            gnt[b]  = req_gnt[PARALLELISM-1:0];
            for (int l = 0; l < PARALLELISM; l++) begin
                if (gnt[b][l]) begin
                    gnt_lane[b] = LANE_W'(l);
                    sel_addr    = 32'(addr_q[l]);
                end
            end
            row_tmp       = row_of(sel_addr, BANK_BITS);
            bank_row[b]   = row_tmp[ROW_W-1:0];
            bank_wdata[b] = wdata_q[gnt_lane[b]];
            bank_en[b]    = issue && (gnt[b] != '0);
            granted       = granted | gnt[b];
        end
        pending_d = pending_q & ~granted;
    end

    assign unused_bits = ^{req_gnt, row_tmp};

    always_comb begin
        state_d = state_q;
        accept  = bus.valid && (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.lane_en == '0) state_d = bus.write ? IDLE : RESP;
                    else                   state_d = ISSUE;
                end
            end
            ISSUE: if (pending_d == '0) state_d = write_q ? IDLE : DRAIN;
            DRAIN: state_d = RESP;
            RESP:  if (bus.rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rd_vld_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= bank_en & {NUMBER_OF_RAMS{~write_q}};
            if (accept)                 pending_q <= bus.lane_en;
            else if (state_q == ISSUE)  pending_q <= pending_d;
            if (accept) begin
                rdata_q <= '0;
            end else begin
                for (int b = 0; b < NUMBER_OF_RAMS; b++)
                    if (rd_vld_q[b]) rdata_q[rd_lane_q[b]] <= bank_dout[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        rd_lane_q <= gnt_lane;
        if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            write_q <= bus.write;
        end
    end

    for (genvar b = 0; b < NUMBER_OF_RAMS; b++) begin : g_bank
        vector_ram_bank #(.DEPTH(ROWS), .DATA_WIDTH(DATA_WIDTH)) u_bank (
            .clk     (clk),
            .en_i    (bank_en[b]),
            .we_i    (write_q),
            .addr_i  (bank_row[b]),
            .wdata_i (bank_wdata[b]),
            .rdata_o (bank_dout[b])
        );
    end

`ifdef VECTOR_BANK_RAM_PERF_EN
    logic [31:0] conflict_q;
    always_ff @(posedge clk) begin
        if (rst)
            conflict_q <= '0;
        else if ((state_q == ISSUE) && (pending_d != '0) && (conflict_q != '1))
            conflict_q <= conflict_q + 32'd1;
    end
    assign conflict_cycles = conflict_q;
`endif

    assign bus.ready  = (state_q == IDLE);
    assign bus.rvalid = (state_q == RESP);
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_vector_bank_ram.sv
// Directed bench for vector_bank_ram: latency, conflicts, masks,
// backpressure and reset during a conflicted write.
module tb_vector_bank_ram;
    localparam int P  = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   lat;

    always #5 clk = ~clk;

    vector_bank_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PARALLELISM(P)) bus ();

`ifdef VECTOR_BANK_RAM_PERF_EN
    logic [31:0] conflict_cycles;
    logic [31:0] cc_base;
`endif

    vector_bank_ram #(
        .NUMBER_OF_RAMS(4), .VECTOR_LENGTH(32), .DATA_WIDTH(DW), .PARALLELISM(P)
    ) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef VECTOR_BANK_RAM_PERF_EN
        .conflict_cycles (conflict_cycles),
`endif
        .bus             (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic wr, input logic [3:0] en,
                             input logic [4*AW-1:0] av, input logic [4*DW-1:0] dv);
        bus.write   = wr;
        bus.lane_en = en;
        bus.addr    = av;
        bus.wdata   = dv;
        bus.valid   = 1'b1;
        check("accept_ready", 32'(bus.ready), 32'd1);
        step();
        bus.valid   = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        while (!bus.rvalid && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic finish_resp();
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        check("post_hs_rvalid", 32'(bus.rvalid), 32'd0);
        check("post_hs_ready", 32'(bus.ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr = '0; bus.wdata = '0; bus.lane_en = '0;
        bus.write = 1'b0; bus.valid = 1'b0; bus.rready = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        for (int l = 0; l < P; l++) check("rst_rdata", bus.rdata[l], 32'd0);
`ifdef VECTOR_BANK_RAM_PERF_EN
        check("rst_conflicts", conflict_cycles, 32'd0);
`endif
        rst = 1'b0;

        // conflict-free write then read of {0,1,2,3}
        issue_req(1'b1, 4'b1111, {5'd3, 5'd2, 5'd1, 5'd0},
                  {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000});
        wait_ready(lat);
        check("wr_cf_latency", 32'(lat), 32'd1);
        issue_req(1'b0, 4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, '0);
        wait_rvalid(lat);
        check("rd_cf_latency", 32'(lat), 32'd2);
        check("rd_cf_l0", bus.rdata[0], 32'hAAAA0000);
        check("rd_cf_l1", bus.rdata[1], 32'hBBBB0001);
        check("rd_cf_l2", bus.rdata[2], 32'hCCCC0002);
        check("rd_cf_l3", bus.rdata[3], 32'hDDDD0003);
        finish_resp();

        // fill bank 0 rows with a fully conflicting write
        issue_req(1'b1, 4'b1111, {5'd16, 5'd12, 5'd8, 5'd4},
                  {32'h0000_0016, 32'h0000_0012, 32'h0000_0008, 32'h0000_0004});
        wait_ready(lat);
        check("wr_conf_latency", 32'(lat), 32'd4);

        // full-conflict read {0,4,8,12}
`ifdef VECTOR_BANK_RAM_PERF_EN
        cc_base = conflict_cycles;
`endif
        issue_req(1'b0, 4'b1111, {5'd12, 5'd8, 5'd4, 5'd0}, '0);
        wait_rvalid(lat);
        check("rd_conf_latency", 32'(lat), 32'd5);
        check("rd_conf_l0", bus.rdata[0], 32'hAAAA0000);
        check("rd_conf_l1", bus.rdata[1], 32'h0000_0004);
        check("rd_conf_l2", bus.rdata[2], 32'h0000_0008);
        check("rd_conf_l3", bus.rdata[3], 32'h0000_0012);
`ifdef VECTOR_BANK_RAM_PERF_EN
        check("conflict_delta", conflict_cycles - cc_base, 32'd3);
`endif
        finish_resp();

        // duplicate write to address 5: highest lane wins
        issue_req(1'b1, 4'b1111, {5'd5, 5'd5, 5'd5, 5'd5}, {32'd4, 32'd3, 32'd2, 32'd1});
        wait_ready(lat);
        check("wr_dup_latency", 32'(lat), 32'd4);
        issue_req(1'b0, 4'b1111, {5'd5, 5'd5, 5'd5, 5'd5}, '0);
        wait_rvalid(lat);
        check("rd_dup_latency", 32'(lat), 32'd5);
        check("rd_dup_l0", bus.rdata[0], 32'd4);
        check("rd_dup_l3", bus.rdata[3], 32'd4);
        finish_resp();

        // lane mask 0101
        issue_req(1'b0, 4'b0101, {5'd3, 5'd2, 5'd1, 5'd0}, '0);
        wait_rvalid(lat);
        check("rd_mask_latency", 32'(lat), 32'd2);
        check("rd_mask_l0", bus.rdata[0], 32'hAAAA0000);
        check("rd_mask_l1", bus.rdata[1], 32'd0);
        check("rd_mask_l2", bus.rdata[2], 32'hCCCC0002);
        check("rd_mask_l3", bus.rdata[3], 32'd0);
        finish_resp();

        // empty-mask write and read
        issue_req(1'b1, 4'b0000, {5'd3, 5'd2, 5'd1, 5'd0}, '1);
        check("wr_empty_ready", 32'(bus.ready), 32'd1);
        issue_req(1'b0, 4'b0000, {5'd3, 5'd2, 5'd1, 5'd0}, '0);
        check("rd_empty_rvalid", 32'(bus.rvalid), 32'd1);
        check("rd_empty_l0", bus.rdata[0], 32'd0);
        finish_resp();

        // backpressure: rready low for 5 cycles in RESP
        issue_req(1'b0, 4'b1111, {5'd0, 5'd1, 5'd2, 5'd3}, '0);
        wait_rvalid(lat);
        check("rd_bp_latency", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            check("bp_rvalid", 32'(bus.rvalid), 32'd1);
            check("bp_ready", 32'(bus.ready), 32'd0);
            check("bp_l0", bus.rdata[0], 32'hDDDD0003);
            check("bp_l3", bus.rdata[3], 32'hAAAA0000);
            step();
        end
        finish_resp();

        // reset during a conflicted write to bank 1: only lane 0 issued
        issue_req(1'b1, 4'b1111, {5'd13, 5'd9, 5'd5, 5'd1},
                  {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011});
        step();
        rst = 1'b1;
        step();
        check("midrst_ready", 32'(bus.ready), 32'd1);
        check("midrst_rvalid", 32'(bus.rvalid), 32'd0);
        rst = 1'b0;
        issue_req(1'b0, 4'b0011, {5'd0, 5'd0, 5'd5, 5'd1}, '0);
        wait_rvalid(lat);
        check("rd_after_rst_latency", 32'(lat), 32'd3);
        check("rd_after_rst_l0", bus.rdata[0], 32'h0000_0011);
        check("rd_after_rst_l1", bus.rdata[1], 32'd4);
        check("rd_after_rst_l2", bus.rdata[2], 32'd0);
        finish_resp();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vector_bank_ram.md
Name: vector_bank_ram

Overview:
- Banked vector scratchpad serving PARALLELISM independent lane addresses per request over NUMBER_OF_RAMS single-port banks.
- Successor to the fixed-config vector RAM; adds bank-conflict serialisation, per-lane enables and a full read-response handshake.
- Sits between vector compute units and the vector operand store.
- One request vector is in flight at a time.

Parameters:
- NUMBER_OF_RAMS, 4: bank count; power of 2, at most VECTOR_LENGTH.
- VECTOR_LENGTH, 32: total words; power of 2, multiple of NUMBER_OF_RAMS.
- DATA_WIDTH, 32: word width.
- PARALLELISM, 4: lanes per request, at least 1.
- ADDR_WIDTH (localparam), $clog2(VECTOR_LENGTH): lane address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- addr  in  ADDR_WIDTH x PARALLELISM  per-lane word address.
- wdata  in  DATA_WIDTH x PARALLELISM  per-lane write data.
- lane_en  in  PARALLELISM  lane participates when 1.
- write  in  1  1 = write vector, 0 = read vector.
- valid  in  1  request valid.
- ready  out  1  request accepted when valid&&ready.
- rdata  out  DATA_WIDTH x PARALLELISM  read response.
- rvalid  out  1  read response valid.
- rready  in  1  response consumed when rvalid&&rready.

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous, active-high.
- Address map: bank = addr[log2(NUMBER_OF_RAMS)-1:0]; row = addr >> log2(NUMBER_OF_RAMS).
- Reset state: state=IDLE, ready=1, rvalid=0, rdata all 0, pending mask 0. RAM contents are not reset.
- Reset mid-operation: abandons the request. Writes already issued persist; unissued ones are dropped.
- IDLE:
  - ready=1.
  - On valid&&ready, latch addr, wdata, write and pending=lane_en, then go to ISSUE.
  - If lane_en==0: a write returns to IDLE; a read goes straight to RESP with rdata zeros.
- ISSUE (ready=0), each cycle:
  - Every bank grants the lowest-index pending lane mapped to it.
  - Granted lanes clear from pending.
  - Write: granted lanes write their bank.
  - Read: each bank returns data the next cycle, captured into rdata[lane] (lane index tracked in a registered grant vector).
  - When pending becomes 0: a write goes to IDLE; a read goes to DRAIN.
- DRAIN: capture the last read data, go to RESP.
- RESP:
  - rvalid=1, rdata stable.
  - On rready, rvalid drops and state goes to IDLE (ready=1 next cycle).
- Latency:
  - Let N = max number of enabled lanes mapping to one bank.
  - Read: rvalid rises N+1 cycles after the accept edge (conflict-free read: 2).
  - Write: ready returns N cycles after the accept edge.
- Duplicate addresses in a write vector: serialised by lane index, so the highest-index lane's data remains.
- Duplicate addresses in a read vector: all such lanes return the same word.
- Disabled lanes: read rdata = 0. They never access a bank.
- No read-during-write hazard exists, since one vector is in flight at a time.

Optional Feature:
- Macro: VECTOR_BANK_RAM_PERF_EN.
- With it: output port conflict_cycles [31:0]. Increments once per ISSUE cycle in which pending is still nonzero after that cycle's grants. Saturates at 0xFFFFFFFF; cleared by rst.
- Without it: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package vector_ram_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, RESP);
  - functions bank_of(addr) and row_of(addr);
  - the per-bank grant/arbitration function (lowest-index pending lane).
- Sub-module vector_ram_bank: single-port synchronous RAM, depth VECTOR_LENGTH/NUMBER_OF_RAMS, 1-cycle read latency, write-first, no content reset. Instantiated NUMBER_OF_RAMS times.

Test Plan:
- Conflict-free write: addr={0,1,2,3}, wdata={A,B,C,D}, all lanes enabled; then read the same addresses. Required: write ready back after 1 cycle; rvalid 2 cycles after accept; rdata={A,B,C,D}.
- Full conflict: read addr={0,4,8,12}, all in bank 0. Required: rvalid 5 cycles after accept; data correct per lane. With VECTOR_BANK_RAM_PERF_EN, conflict_cycles=3.
- Duplicate write: addr={5,5,5,5}, wdata={1,2,3,4}, then read addr 5. Required: value 4.
- Lane mask: lane_en=4'b0101 on a read of {0,1,2,3}. Required: rdata lanes 1 and 3 = 0; lanes 0 and 2 correct; latency 2.
- Backpressure: rready held low 5 cycles in RESP. Required: rvalid and rdata held stable; ready=0 throughout; ready=1 the cycle after the rready handshake.
- Reset mid-ISSUE: assert rst during a conflicted write. Required: next cycle ready=1, rvalid=0; a subsequent read of the issued lanes returns the new data.
